// File: rtl/serial_pkg.sv
// Shared definitions for the serial transmitter and its matching receiver.
// Frame state encoding and default frame geometry.
package serial_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } serial_state_e;

  localparam int DEF_DATA_W       = 8;
  localparam int DEF_CLKS_PER_BIT = 4;

endpackage

// File: rtl/baud_tick.sv
// Bit-period timer: down-counter reloaded at terminal count or on clear.
// tick marks the last cycle of a bit; tick_next is the same flag one cycle early.
module baud_tick #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic clr,
  output logic tick,
  output logic tick_next
);

  localparam logic [7:0] TC_LOAD = 8'(CLKS_PER_BIT - 1);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q - 8'd1;
    if (clr || (cnt_q == 8'd0)) cnt_d = TC_LOAD;
  end

  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign tick      = (cnt_q == 8'd0);
  assign tick_next = (cnt_d == 8'd0);

endmodule

// File: rtl/serial_tx.sv
// Serial frame transmitter: start bit, LSB-first payload, optional even parity, stop bit.
// Parity bit is compiled in only when SERIAL_TX_PARITY_EN is defined.
//
// state    | meaning
// S_IDLE   | line idle (tx=1), waiting for load
// S_START  | driving start bit (tx=0)
// S_DATA   | shifting payload out LSB first
// S_PARITY | driving even parity of captured payload
// S_STOP   | driving stop bit (tx=1), done in last cycle
module serial_tx
  import serial_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic              clk,
  input  logic              r,
  input  logic [DATA_W-1:0] d,
  input  logic              load,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  serial_state_e     state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic              tx_q, tx_d, busy_q, busy_d, done_q, done_d;
  logic              accept, tick, tick_next;
`ifdef SERIAL_TX_PARITY_EN
  logic              parity_q, parity_d;
`endif

  assign accept = (state_q == S_IDLE) && load && !r;

  // Restarting the timer on accept aligns the start bit to the load edge.
  baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud_tick (
    .clk       (clk),
    .clr       (r || accept),
    .tick      (tick),
    .tick_next (tick_next)
  );

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    bit_d    = bit_q;
`ifdef SERIAL_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d  = S_START;
          shift_d  = d;
          bit_d    = '0;
`ifdef SERIAL_TX_PARITY_EN
          parity_d = ^d;
`endif
        end
      end
      S_START: if (tick) state_d = S_DATA;
      S_DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 1'b1;
          if (bit_q == LAST_BIT) begin
            bit_d = '0;
`ifdef SERIAL_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      S_PARITY: if (tick) state_d = S_STOP;
`endif
      S_STOP: if (tick) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from next-state values so they can be registered.
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_STOP) && tick_next;
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
`ifdef SERIAL_TX_PARITY_EN
      S_PARITY: tx_d = parity_d;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (r) begin
      state_q  <= S_IDLE;
      shift_q  <= '0;
      bit_q    <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      bit_q    <= bit_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef SERIAL_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: DUT A at 4 clocks/bit, DUT B at 1 clock/bit, checked against a frame model.
// Define SERIAL_TX_PARITY_EN for both bench and RTL to cover the parity build.
module tb_serial_tx;

  localparam int W = 8;
`ifdef SERIAL_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int CPB = 4;
  localparam int NB  = 2 + W + P;
  localparam int FL  = NB * CPB;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         r_a = 1'b1, load_a = 1'b0, r_b = 1'b1, load_b = 1'b0;
  logic [W-1:0] d_a = '0, d_b = '0;
  logic         tx_a, busy_a, done_a, tx_b, busy_b, done_b;

  int errors = 0;
  int checks = 0;
  logic [2:0] obs [0:511];

  serial_tx #(.DATA_W(W), .CLKS_PER_BIT(CPB)) u_a (
    .clk(clk), .r(r_a), .d(d_a), .load(load_a), .tx(tx_a), .busy(busy_a), .done(done_a));
  serial_tx #(.DATA_W(W), .CLKS_PER_BIT(1)) u_b (
    .clk(clk), .r(r_b), .d(d_b), .load(load_b), .tx(tx_b), .busy(busy_b), .done(done_b));

  // Frame bit idx: 0 start, 1..W payload LSB first, then parity (if built), then stop.
  function automatic logic exp_bit(input logic [W-1:0] dv, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= W) return dv[idx-1];
    if (P == 1 && idx == W + 1) return ^dv;
    return 1'b1;
  endfunction

  task automatic start_a(input logic [W-1:0] dv);
    @(posedge clk); #1; d_a = dv; load_a = 1'b1;
    @(posedge clk); #1; load_a = 1'b0; d_a = W'($urandom);
  endtask

  task automatic start_b(input logic [W-1:0] dv);
    @(posedge clk); #1; d_b = dv; load_b = 1'b1;
    @(posedge clk); #1; load_b = 1'b0; d_b = W'($urandom);
  endtask

  // Records {tx,busy,done} for cycles 1..n after an accepted load; kind 1 pulses r, kind 2 pulses load.
  task automatic sample_a(input int n, input int inj_c, input int kind, input logic [W-1:0] inj_d);
    for (int c = 1; c <= n; c++) begin
      if (c == inj_c) begin
        if (kind == 1) r_a = 1'b1;
        if (kind == 2) begin load_a = 1'b1; d_a = inj_d; end
      end else if (inj_c > 0 && c == inj_c + 1) begin
        r_a = 1'b0;
        if (kind == 2) load_a = 1'b0;
      end
      @(negedge clk);
      obs[c] = {tx_a, busy_a, done_a};
      @(posedge clk); #1;
    end
  endtask

  task automatic sample_b(input int n);
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      obs[c] = {tx_b, busy_b, done_b};
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    r_a = 1'b1; r_b = 1'b1; load_a = 1'b1; load_b = 1'b1;
    d_a = W'($urandom); d_b = W'($urandom);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({tx_a, busy_a, done_a} !== 3'b100) begin
      errors++; $display("FAIL reset_a tx/busy/done got %b want 100", {tx_a, busy_a, done_a});
    end
    checks++;
    if ({tx_b, busy_b, done_b} !== 3'b100) begin
      errors++; $display("FAIL reset_b tx/busy/done got %b want 100", {tx_b, busy_b, done_b});
    end
    @(posedge clk); #1;
    r_a = 1'b0; r_b = 1'b0; load_a = 1'b0; load_b = 1'b0;
    @(negedge clk);
    checks++;
    if ({tx_a, busy_a, done_a} !== 3'b100) begin
      errors++; $display("FAIL reset_prio_a tx/busy/done got %b want 100", {tx_a, busy_a, done_a});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_frame(input string name, input logic [W-1:0] dv, input int inj_c, input int kind);
    int nbusy;
    nbusy = 0;
    start_a(dv);
    sample_a(FL + 1, inj_c, kind, 8'h00);
    for (int c = 1; c <= FL + 1; c++) begin
      logic [2:0] ex;
      ex = (c <= FL) ? {exp_bit(dv, (c - 1) / CPB), 1'b1, 1'(c == FL)} : 3'b100;
      if (obs[c][1]) nbusy++;
      checks++;
      if (obs[c] !== ex) begin
        errors++;
        $display("FAIL %s cycle %0d tx/busy/done got %b want %b", name, c, obs[c], ex);
      end
    end
    checks++;
    if (nbusy != FL) begin
      errors++; $display("FAIL %s busy_len got %0d want %0d", name, nbusy, FL);
    end
  endtask

  task automatic test_reset_abort;
    logic [W-1:0] dv;
    dv = W'($urandom);
    start_a(dv);
    sample_a(14, 10, 1, 8'h00);
    for (int c = 1; c <= 14; c++) begin
      logic [2:0] ex;
      ex = (c <= 10) ? {exp_bit(dv, (c - 1) / CPB), 2'b10} : 3'b100;
      checks++;
      if (obs[c] !== ex) begin
        errors++;
        $display("FAIL abort cycle %0d tx/busy/done got %b want %b", c, obs[c], ex);
      end
    end
    test_frame("after_abort_3c", 8'h3C, 0, 0);
  endtask

  task automatic test_back_to_back;
    int n;
    n = 3 * (FL + 1) - 1;
    start_a(8'hFF);
    load_a = 1'b1; d_a = 8'hFF;
    sample_a(n, 0, 0, 8'h00);
    load_a = 1'b0;
    for (int c = 1; c <= n; c++) begin
      int k;
      logic [2:0] ex;
      k = (c - 1) % (FL + 1);
      ex = (k < FL) ? {exp_bit(8'hFF, k / CPB), 1'b1, 1'(k == FL - 1)} : 3'b100;
      checks++;
      if (obs[c] !== ex) begin
        errors++;
        $display("FAIL back_to_back cycle %0d tx/busy/done got %b want %b", c, obs[c], ex);
      end
    end
  endtask

  task automatic test_cpb1;
    start_b(8'h81);
    sample_b(NB + 1);
    for (int c = 1; c <= NB + 1; c++) begin
      logic [2:0] ex;
      ex = (c <= NB) ? {exp_bit(8'h81, c - 1), 1'b1, 1'(c == NB)} : 3'b100;
      checks++;
      if (obs[c] !== ex) begin
        errors++;
        $display("FAIL cpb1 cycle %0d tx/busy/done got %b want %b", c, obs[c], ex);
      end
    end
  endtask

`ifdef SERIAL_TX_PARITY_EN
  task automatic test_parity;
    int pc;
    pc = (W + 1) * CPB + 1;
    test_frame("parity_07", 8'h07, 0, 0);
    checks++;
    if (obs[pc][2] !== 1'b1) begin
      errors++; $display("FAIL parity_07_bit got %b want 1", obs[pc][2]);
    end
    test_frame("parity_03", 8'h03, 0, 0);
    checks++;
    if (obs[pc][2] !== 1'b0) begin
      errors++; $display("FAIL parity_03_bit got %b want 0", obs[pc][2]);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_frame("a5", 8'hA5, 0, 0);
    test_frame("a5_load_ignored", 8'hA5, 12, 2);
    test_reset_abort();
    for (int i = 0; i < 4; i++) test_frame("random", W'($urandom), 0, 0);
    test_back_to_back();
    repeat (FL + 2) @(posedge clk);
    #1;
    test_cpb1();
`ifdef SERIAL_TX_PARITY_EN
    test_parity();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_tx.md
SERIAL_TX -- requirements
Module: serial_tx

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning frame payload width in bits.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 4, meaning clock cycles each serial bit is held on tx (legal range 1..255).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port r  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port d  input  DATA_W  parallel payload, sampled only on an accepted load.
REQ-006 SHALL have port load  input  1  transmit request; accepted only in a cycle with busy=0.
REQ-007 SHALL have port tx  output  1  serial line; idle level 1.
REQ-008 SHALL have port busy  output  1  high from the cycle after an accepted load until the frame completes.
REQ-009 SHALL have port done  output  1  one-cycle pulse in the last cycle of the stop bit.

Function
REQ-010 SHALL implement states IDLE, START, DATA, PARITY, STOP; transitions: IDLE->START on accepted load, START->DATA, DATA->PARITY (PARITY_EN only) or STOP after the bit DATA_W-1, PARITY->STOP, STOP->IDLE.
REQ-011 SHALL, in IDLE, drive tx=1, busy=0, done=0.
REQ-012 SHALL capture d into an internal shift register on the clk edge that accepts load; later changes on d SHALL NOT affect the frame.
REQ-013 SHALL drive the start bit tx=0 beginning the cycle after the accepted load, for exactly CLKS_PER_BIT cycles.
REQ-014 SHALL send data LSB first, each bit held CLKS_PER_BIT cycles.
REQ-015 SHALL drive the stop bit tx=1 for CLKS_PER_BIT cycles, assert done in its final cycle, and return to IDLE (busy=0) on the next cycle.
REQ-016 SHALL keep busy high for exactly (2+DATA_W+P)*CLKS_PER_BIT cycles per frame, where P=1 with PARITY_EN and P=0 without it.
REQ-017 SHALL ignore load while busy=1, with no queuing and no effect on the frame in flight.
REQ-018 SHALL, when load is held high continuously, start a new frame after exactly one IDLE cycle (tx=1, busy=0).
REQ-019 SHALL have tx glitch-free (registered output) with no combinational path from d or load to tx.
REQ-020 SHALL support CLKS_PER_BIT=1 with the same state sequence and one cycle per bit.

Reset
REQ-021 SHALL, with r=1 at a clk edge, force IDLE, tx=1, busy=0, done=0, and clear the bit/tick counters and shift register.
REQ-022 SHALL abort any frame in progress on r; no done pulse for the aborted frame.
REQ-023 SHALL give r priority over load in the same cycle (load not accepted).

Configuration
REQ-024 SHALL compile in an even-parity bit when macro SERIAL_TX_PARITY_EN is defined: the PARITY state drives XOR of the captured payload for CLKS_PER_BIT cycles between the last data bit and the stop bit.
REQ-025 SHALL, without SERIAL_TX_PARITY_EN, omit the PARITY state and its logic entirely, with DATA going directly to STOP.

Structure
REQ-026 SHALL place the state encoding (IDLE..STOP) and default DATA_W/CLKS_PER_BIT constants in shared package serial_pkg, for reuse by the matching receiver.
REQ-027 SHALL use one sub-module, baud_tick, a CLKS_PER_BIT modulo counter with a synchronous clear that emits a one-cycle bit-boundary tick; the FSM and shift register stay in serial_tx.

Verification
REQ-028 SHALL verify CLKS_PER_BIT=4, no parity, load with d=0xA5: tx = 0 x4, then 1,0,1,0,0,1,0,1 each x4, then 1 x4; busy high 40 cycles; single done in cycle 40.
REQ-029 SHALL verify load with d=0x00 at cycle 12 of the 0xA5 frame: it is ignored and the tx waveform is identical to REQ-028.
REQ-030 SHALL verify r pulsed at cycle 10 of a frame: next cycle tx=1, busy=0, no done; a subsequent load with d=0x3C produces a complete, correct frame.
REQ-031 SHALL verify SERIAL_TX_PARITY_EN with d=0x07: parity bit 1 and busy=44 cycles; with d=0x03: parity bit 0.
REQ-032 SHALL verify load held high with d=0xFF: consecutive frames separated by exactly one idle cycle with tx=1 and busy=0.
REQ-033 SHALL verify CLKS_PER_BIT=1 with d=0x81: tx sequence 0,1,0,0,0,0,0,0,1,1 over 10 cycles, with done in the 10th cycle.
